// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: load/store funct3 encodings and the
// data-memory access FSM state type.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Load/store lane alignment: byte strobes and replicated store data, load lane
// extraction with sign/zero extension, and the natural-alignment check.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_unsigned;

    // Size-dependent strobe, replication, extraction and alignment
    always_comb begin
        wstrb       = 4'b0000;
        wdata       = store_data;
        load_data   = load_word;
        misaligned  = 1'b0;
        byte_sel    = load_word[{addr_lo, 3'b000} +: 8];
        half_sel    = load_word[{addr_lo[1], 4'b0000} +: 16];
        is_unsigned = (funct3 == F3_BU) || (funct3 == F3_HU);

        case (funct3)
            F3_B, F3_BU: begin
                if (is_store) wstrb = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = is_unsigned ? {24'b0, byte_sel}
                                        : {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H, F3_HU: begin
                misaligned = addr_lo[0];
                if (is_store) wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                wdata     = {2{store_data[15:0]}};
                load_data = is_unsigned ? {16'b0, half_sel}
                                        : {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                misaligned = |addr_lo;
                if (is_store) wstrb = 4'b1111;
            end
            default: begin
                misaligned = |addr_lo;
                if (is_store) wstrb = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the M-stage instruction: issues the
// req/gnt/rvalid transaction, stalls F/D/E/M and bubbles MEM/WB while the
// access is outstanding, and returns the extended load result.
// Optional watchdog: define DMEM_TIMEOUT_EN to abort a stuck access after
// TIMEOUT_CYCLES waiting cycles with a BusErrM pulse and zero load data.
module dmem_access_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        funct3M,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              StallM,
    output logic              ClearW,
    output logic [31:0]       ReadDataM,
    output logic              MisalignedM,
    output logic              BusErrM
);

    dmem_state_t       state_q, state_d;

    logic              op_we_q;
    logic [2:0]        op_f3_q;
    logic [ADDR_W-1:0] op_addr_q;
    logic [31:0]       op_wdata_q;
    logic [31:0]       read_data_q;

    logic              live;
    logic              sel_we;
    logic [2:0]        sel_f3;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;

    logic [3:0]        al_wstrb;
    logic [31:0]       al_wdata;
    logic [31:0]       al_load;
    logic              al_misaligned;

    logic              req_c;
    logic              stall_c;
    logic              mis_c;
    logic              rd_load_c;
    logic              expire_c;
    logic              timeout_hit;

    // Request fields come straight from M in IDLE, from the captured copy afterwards
    assign live      = (state_q == IDLE);
    assign sel_we    = live ? MemWriteM  : op_we_q;
    assign sel_f3    = live ? funct3M    : op_f3_q;
    assign sel_addr  = live ? ALUResultM : op_addr_q;
    assign sel_wdata = live ? WriteDataM : op_wdata_q;

    lsu_align u_align (
        .funct3     (sel_f3),
        .is_store   (sel_we),
        .addr_lo    (sel_addr[1:0]),
        .store_data (sel_wdata),
        .load_word  (dmem_rdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misaligned (al_misaligned)
    );

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;

    // Fires on the TIMEOUT_CYCLES-th cycle spent in REQ/WAIT
    assign timeout_hit = ((state_q == REQ) || (state_q == WAIT)) &&
                         ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));

    // Watchdog counter: zero outside REQ/WAIT so it starts fresh on entry
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= expire_c;
            if ((state_q == REQ) || (state_q == WAIT)) cnt_q <= cnt_q + CNT_W'(1);
            else                                       cnt_q <= '0;
        end
    end

    assign BusErrM = !reset && bus_err_q;
`else
    logic timeout_unused;

    assign timeout_unused = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
    assign BusErrM        = 1'b0;
`endif

    // State register, captured request and load result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_we_q     <= 1'b0;
            op_f3_q     <= 3'b000;
            op_addr_q   <= '0;
            op_wdata_q  <= '0;
            read_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (live) begin
                op_we_q    <= MemWriteM;
                op_f3_q    <= funct3M;
                op_addr_q  <= ALUResultM;
                op_wdata_q <= WriteDataM;
            end
            if (expire_c)       read_data_q <= '0;
            else if (rd_load_c) read_data_q <= al_load;
        end
    end

    // Next state and per-state control
    always_comb begin
        state_d   = state_q;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        mis_c     = 1'b0;
        rd_load_c = 1'b0;
        expire_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (MemReadM || MemWriteM) begin
                    if (al_misaligned) begin
                        mis_c = 1'b1;
                    end else begin
                        req_c   = 1'b1;
                        stall_c = 1'b1;
                        if (dmem_gnt) state_d = MemWriteM ? DONE : WAIT;
                        else          state_d = REQ;
                    end
                end
            end
            REQ: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (dmem_gnt) begin
                    state_d = op_we_q ? DONE : WAIT;
                end else if (timeout_hit) begin
                    expire_c = 1'b1;
                    state_d  = DONE;
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (dmem_rvalid) begin
                    rd_load_c = 1'b1;
                    state_d   = DONE;
                end else if (timeout_hit) begin
                    expire_c = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Everything is forced quiet while reset is held
    assign dmem_req    = !reset && req_c;
    assign dmem_we     = dmem_req && sel_we;
    assign dmem_addr   = dmem_req ? {sel_addr[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_wdata  = dmem_we ? al_wdata : '0;
    assign dmem_wstrb  = dmem_req ? al_wstrb : 4'b0000;
    assign StallM      = !reset && stall_c;
    assign ClearW      = !reset && stall_c;
    assign MisalignedM = !reset && mis_c;
    assign ReadDataM   = reset ? '0 : read_data_q;

endmodule
